// File: rtl/posit_div_err_if.sv
// posit_div_err_if: divider result / golden reference sample bus
interface posit_div_err_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic [N-1:0] dut_out;
    logic [N-1:0] golden;
    logic         last;

    modport master (output in_valid, dut_out, golden, last);
    modport slave  (input  in_valid, dut_out, golden, last);
endinterface

// File: rtl/posit_div_err_monitor.sv
// posit_div_err_monitor: classifies posit divider error per sample and accumulates run statistics
module posit_div_err_monitor #(
    parameter int N   = 8,
    parameter int CW  = 17,
    parameter int THR = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    posit_div_err_if.slave        smp_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CW-1:0]         sample_cnt_o,
    output logic [CW-1:0]         exact_cnt_o,
    output logic [CW-1:0]         ulp1_cnt_o,
    output logic [CW-1:0]         big_cnt_o,
    output logic [CW-1:0]         nar_cnt_o,
    output logic [N-1:0]          max_diff_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    state_t        state_q;
    logic          busy_q, done_q;
    logic [CW-1:0] sample_q, exact_q, ulp1_q, big_q, nar_q;
    logic [N-1:0]  max_q;
    logic [N:0]    sub_d;
    logic [N-1:0]  diff_d;
    logic          nar1_d;

    function automatic logic [CW-1:0] inc(input logic [CW-1:0] c);
        return (&c) ? c : c + CW'(1);
    endfunction

    // Signed (posit order) distance; both-NaR naturally yields diff 0 and counts as exact
    always_comb begin
        sub_d  = {smp_i.dut_out[N-1], smp_i.dut_out} - {smp_i.golden[N-1], smp_i.golden};
        diff_d = sub_d[N] ? N'(~sub_d + 1'b1) : sub_d[N-1:0];
        nar1_d = (smp_i.dut_out == NAR) != (smp_i.golden == NAR);
    end

    // Run FSM and statistics; start from any state (re)enters RUN with cleared statistics
    always_ff @(posedge clk) begin
        if (!rst_n || start_i) begin
            state_q  <= rst_n ? RUN : IDLE;
            busy_q   <= rst_n;
            done_q   <= 1'b0;
            sample_q <= '0;
            exact_q  <= '0;
            ulp1_q   <= '0;
            big_q    <= '0;
            nar_q    <= '0;
            max_q    <= '0;
        end else if (state_q == RUN && smp_i.in_valid) begin
            sample_q <= inc(sample_q);
            if (nar1_d) begin
                nar_q <= inc(nar_q);
            end else begin
                if (diff_d == '0) exact_q <= inc(exact_q);
                if (diff_d == N'(1)) ulp1_q <= inc(ulp1_q);
                if (diff_d >= N'(THR)) big_q <= inc(big_q);
                if (diff_d > max_q) max_q <= diff_d;
            end
            if (smp_i.last) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign sample_cnt_o = sample_q;
    assign exact_cnt_o  = exact_q;
    assign ulp1_cnt_o   = ulp1_q;
    assign big_cnt_o    = big_q;
    assign nar_cnt_o    = nar_q;
    assign max_diff_o   = max_q;
endmodule
